ssd2hex_capture: RTL

- Receive end of the seven-segment display path: snoops a scanned, multiplexed active-low segment/anode bus and recovers the hex digit shown in each position.
- Filters scan glitches with a stability counter, decodes the segment pattern back to a 4-bit value, and holds a per-digit register file.
- Each digit change is reported on a valid/ready event port, so self-test logic or a debug UART can check what the display is actually showing.

---
 rtl/ssd2hex_capture.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/ssd2hex_capture.sv
// Snoops a multiplexed active-low seven-segment bus and recovers the hex digit
// shown at each position, reporting digit changes on a one-entry event port.
module ssd2hex_capture #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4,
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1,
  localparam int CW = $clog2(STABLE_CYCLES + 1)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [6:0]            ssd_i,
  input  logic [DIGITS-1:0]     an_i,
  output logic [4*DIGITS-1:0]   hex_o,
  output logic [DIGITS-1:0]     digit_valid_o,
  output logic                  err_o,
  output logic                  evt_valid_o,
  input  logic                  evt_ready_i,
  output logic [IW-1:0]         evt_digit_o,
  output logic [3:0]            evt_hex_o,
  output logic                  ovf_o
);

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    LOCKED
  } state_t;

  state_t              state;
  logic [CW-1:0]       count;
  logic [6:0]          ssd_q;
  logic [DIGITS-1:0]   an_q;
  logic [6:0]          prev_ssd;
  logic [DIGITS-1:0]   prev_an;

  logic [IW-1:0]       an_idx;
  int                  low_cnt;
  logic                an_legal;
  logic                same_pair;
  logic                accept;
  logic                dec_legal;
  logic [3:0]          dec_val;
  logic                new_evt;
  logic                xfer;

  // Bit 4 flags a recognised digit; blank and garbage both come back as 0.
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'h40:   decode = 5'h10;
      7'h79:   decode = 5'h11;
      7'h24:   decode = 5'h12;
      7'h30:   decode = 5'h13;
      7'h19:   decode = 5'h14;
      7'h12:   decode = 5'h15;
      7'h02:   decode = 5'h16;
      7'h78:   decode = 5'h17;
      7'h00:   decode = 5'h18;
      7'h18:   decode = 5'h19;
      7'h08:   decode = 5'h1A;
      7'h03:   decode = 5'h1B;
      7'h46:   decode = 5'h1C;
      7'h21:   decode = 5'h1D;
      7'h06:   decode = 5'h1E;
      7'h0E:   decode = 5'h1F;
      default: decode = 5'h00;
    endcase
  endfunction

  always_comb begin
    an_idx  = '0;
    low_cnt = 0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!an_q[i]) begin
        an_idx  = IW'(i);
        low_cnt = low_cnt + 1;
      end
    end
    an_legal  = (low_cnt == 1);
    same_pair = (an_q == prev_an) && (ssd_q == prev_ssd);
    {dec_legal, dec_val} = decode(ssd_q);
    accept  = an_legal && (state == TRACK) && same_pair &&
              (count == CW'(STABLE_CYCLES - 1));
    new_evt = accept && dec_legal &&
              (!digit_valid_o[an_idx] || (hex_o[4*an_idx +: 4] != dec_val));
    xfer    = evt_valid_o && evt_ready_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ssd_q         <= 7'h7F;
      an_q          <= '1;
      prev_ssd      <= 7'h7F;
      prev_an       <= '1;
      state         <= IDLE;
      count         <= '0;
      hex_o         <= '0;
      digit_valid_o <= '0;
      err_o         <= 1'b0;
      evt_valid_o   <= 1'b0;
      evt_digit_o   <= '0;
      evt_hex_o     <= '0;
      ovf_o         <= 1'b0;
    end else begin
      ssd_q    <= ssd_i;
      an_q     <= an_i;
      prev_ssd <= ssd_q;
      prev_an  <= an_q;
      err_o    <= 1'b0;

      if (!an_legal) begin
        state <= IDLE;
        count <= '0;
      end else begin
        case (state)
          IDLE: begin
            state <= TRACK;
            count <= CW'(1);
          end
          TRACK: begin
            if (!same_pair) begin
              count <= CW'(1);
            end else if (accept) begin
              state <= LOCKED;
              count <= CW'(STABLE_CYCLES);
            end else begin
              count <= count + 1'b1;
            end
          end
          LOCKED: begin
            if (!same_pair) begin
              state <= TRACK;
              count <= CW'(1);
            end
          end
          default: begin
            state <= IDLE;
            count <= '0;
          end
        endcase
      end

      if (accept) begin
        if (dec_legal) begin
          hex_o[4*an_idx +: 4]  <= dec_val;
          digit_valid_o[an_idx] <= 1'b1;
        end else if (ssd_q == 7'h7F) begin
          digit_valid_o[an_idx] <= 1'b0;
        end else begin
          err_o <= 1'b1;
        end
      end

      // A full holding register that is not draining keeps its old event.
      if (new_evt) begin
        if (!evt_valid_o || xfer) begin
          evt_valid_o <= 1'b1;
          evt_digit_o <= an_idx;
          evt_hex_o   <= dec_val;
        end else begin
          ovf_o <= 1'b1;
        end
      end else if (xfer) begin
        evt_valid_o <= 1'b0;
      end
    end
  end

endmodule
